counter_seq: RTL and testbench

- Round-robin sequencer that shares one loadable up/down counter (WIDTH-bit, active-low load, ce, up_down) between NUM_REQ requesters.
- Each granted job loads a start value, then counts STEPS cycles in a chosen direction, then returns the final count to the requester.
- Sits between the requester logic and the counter instance; it is the only driver of the counter's load_n, ce, up_down and data_load.

---
 rtl/cnt_seq_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/counter_seq.sv | 162 ++++++++++++++++
 tb/tb_counter_seq.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_seq_pkg.sv
// Shared types and default sizes for the counter_seq round-robin counter sequencer.
package cnt_seq_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 4;
  localparam int DEF_STEP_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COUNT,
    ST_SETTLE,
    ST_DONE
  } seq_state_e;

  // Job layout for the default configuration; counter_seq mirrors it at its own widths.
  typedef struct packed {
    logic [DEF_WIDTH-1:0]  load;
    logic                  dir;
    logic [DEF_STEP_W-1:0] steps;
  } seq_job_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after i_ptr, wrapping.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx
);

  always_comb begin
    int j;
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    o_gnt = '0;
    o_idx = '0;
    j     = 0;
    if (i_en) begin
      // Walk from the farthest candidate back to i_ptr so the nearest request wins.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        j = int'(i_ptr) + k;
        if (j >= NUM_REQ) j -= NUM_REQ;
        if (i_req[j]) begin
          o_gnt    = '0;
          o_gnt[j] = 1'b1;
          o_idx    = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/counter_seq.sv
// Round-robin sequencer sharing one loadable up/down counter between NUM_REQ requesters.
// Optional macro CNT_SEQ_ABORT_EN adds the abort input and aborted output.
module counter_seq
  import cnt_seq_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  parameter  int WIDTH   = DEF_WIDTH,
  parameter  int STEP_W  = DEF_STEP_W,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*WIDTH-1:0]  req_load,
  input  logic [NUM_REQ-1:0]        req_dir,
  input  logic [NUM_REQ*STEP_W-1:0] req_steps,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      done,
  output logic [ID_W-1:0]           done_id,
  output logic [WIDTH-1:0]          result,
  output logic                      busy,
  output logic                      load_n,
  output logic                      ce,
  output logic                      up_down,
  output logic [WIDTH-1:0]          data_load,
  input  logic [WIDTH-1:0]          count_out
`ifdef CNT_SEQ_ABORT_EN
  ,
  input  logic                      abort,
  output logic                      aborted
`endif
);

  typedef struct packed {
    logic [WIDTH-1:0]  load;
    logic              dir;
    logic [STEP_W-1:0] steps;
  } job_t;

  seq_state_e          r_state, w_state_nxt;
  job_t                r_job, w_sel_job;
  logic [ID_W-1:0]     r_ptr, r_id, r_done_id, w_arb_idx, w_ptr_nxt;
  logic [NUM_REQ-1:0]  r_gnt, w_arb_gnt;
  logic [STEP_W-1:0]   r_remain;
  logic [WIDTH-1:0]    r_result, r_data_load;
  logic                r_done, r_busy, r_load_n, r_ce, r_up_down;
  logic                w_arb_en, w_capture, w_abort;

  assign w_arb_en  = (r_state == ST_IDLE);
  assign w_capture = |w_arb_gnt;
  assign w_ptr_nxt = (w_arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_arb_idx + 1'b1;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req (req),
    .i_ptr (r_ptr),
    .i_en  (w_arb_en),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx)
  );

  always_comb begin
    w_sel_job = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_arb_idx == ID_W'(i)) begin
        w_sel_job.load  = req_load[i*WIDTH +: WIDTH];
        w_sel_job.dir   = req_dir[i];
        w_sel_job.steps = req_steps[i*STEP_W +: STEP_W];
      end
    end
  end

`ifdef CNT_SEQ_ABORT_EN
  logic r_abort_flag, r_aborted;
  assign w_abort = abort && (r_state == ST_LOAD || r_state == ST_COUNT);
  assign aborted = r_aborted;
`else
  assign w_abort = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_capture) w_state_nxt = ST_LOAD;
      ST_LOAD:   w_state_nxt = (w_abort || r_job.steps == '0) ? ST_SETTLE : ST_COUNT;
      ST_COUNT:  if (w_abort || r_remain == STEP_W'(1)) w_state_nxt = ST_SETTLE;
      ST_SETTLE: w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Counter controls are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_job       <= '0;
      r_id        <= '0;
      r_ptr       <= '0;
      r_remain    <= '0;
      r_gnt       <= '0;
      r_done      <= 1'b0;
      r_done_id   <= '0;
      r_result    <= '0;
      r_busy      <= 1'b0;
      r_load_n    <= 1'b1;
      r_ce        <= 1'b0;
      r_up_down   <= 1'b0;
      r_data_load <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      r_state     <= w_state_nxt;
      r_gnt       <= w_arb_gnt;
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_load_n    <= (w_state_nxt != ST_LOAD);
      r_ce        <= (w_state_nxt == ST_COUNT);
      r_up_down   <= (w_state_nxt == ST_COUNT) && r_job.dir;
      r_data_load <= (w_state_nxt == ST_LOAD) ? w_sel_job.load : '0;
      r_done      <= (r_state == ST_DONE);
      if (w_capture) begin
        r_job <= w_sel_job;
        r_id  <= w_arb_idx;
        r_ptr <= w_ptr_nxt;
      end
      if (r_state == ST_LOAD) begin
        r_remain <= r_job.steps;
      end else if (r_state == ST_COUNT) begin
        r_remain <= r_remain - 1'b1;
      end
      if (r_state == ST_DONE) begin
        r_result  <= count_out;
        r_done_id <= r_id;
      end
    end
  end

`ifdef CNT_SEQ_ABORT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_abort_flag <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      if (w_capture) begin
        r_abort_flag <= 1'b0;
      end else if (w_abort) begin
        r_abort_flag <= 1'b1;
      end
      r_aborted <= (r_state == ST_DONE) && r_abort_flag;
    end
  end
`endif

  assign gnt       = r_gnt;
  assign done      = r_done;
  assign done_id   = r_done_id;
  assign result    = r_result;
  assign busy      = r_busy;
  assign load_n    = r_load_n;
  assign ce        = r_ce;
  assign up_down   = r_up_down;
  assign data_load = r_data_load;

endmodule

// File: tb/tb_counter_seq.sv
// Bench for counter_seq: external counter, job-level reference model, directed job scenarios.
// Build with CNT_SEQ_ABORT_EN defined to also exercise the abort path.
module tb_counter_seq;
  import cnt_seq_pkg::*;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int SW = 8;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*W-1:0]  req_load;
  logic [N-1:0]    req_dir;
  logic [N*SW-1:0] req_steps;
  logic [N-1:0]    gnt;
  logic            done;
  logic [IW-1:0]   done_id;
  logic [W-1:0]    result;
  logic            busy, load_n, ce, up_down;
  logic [W-1:0]    data_load;
  logic [W-1:0]    count_out;
`ifdef CNT_SEQ_ABORT_EN
  logic            abort;
  logic            aborted;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit ce_seen;

  always #5 clk = ~clk;

  counter_seq #(.NUM_REQ(N), .WIDTH(W), .STEP_W(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_load  (req_load),
    .req_dir   (req_dir),
    .req_steps (req_steps),
    .gnt       (gnt),
    .done      (done),
    .done_id   (done_id),
    .result    (result),
    .busy      (busy),
    .load_n    (load_n),
    .ce        (ce),
    .up_down   (up_down),
    .data_load (data_load),
    .count_out (count_out)
`ifdef CNT_SEQ_ABORT_EN
    ,
    .abort     (abort),
    .aborted   (aborted)
`endif
  );

  // The shared counter: active-low synchronous load beats count enable, wraps mod 2^W.
  always @(posedge clk or posedge rst) begin
    if (rst)          count_out <= '0;
    else if (!load_n) count_out <= data_load;
    else if (ce)      count_out <= up_down ? count_out + 1'b1 : count_out - 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one job at a time, round-robin grant, result = load +/- steps mod 2^W.
  int           m_ptr, m_el, m_done_at, m_steps, m_id, m_load;
  bit           m_job, m_dir, m_ab;
  logic [W-1:0] m_exp;
  logic [N-1:0] exp_gnt;
  bit           exp_done, exp_busy, exp_ab;
  logic [IW-1:0] exp_id;
  logic [W-1:0] exp_res;

  always @(negedge clk) begin : monitor
    int  idx, tmp;
    bit  found;
    if (ce) ce_seen = 1'b1;
    if (rst) begin
      m_ptr = 0; m_job = 0; m_el = 0; m_ab = 0;
      exp_gnt = '0; exp_done = 0; exp_busy = 0; exp_res = '0; exp_id = '0; exp_ab = 0;
    end
    check("mon_gnt", gnt, exp_gnt);
    check("mon_done", done, exp_done);
    check("mon_busy", busy, exp_busy);
    check("mon_result", result, exp_res);
    check("mon_load_ce_excl", (!load_n && ce), 0);
    if (exp_done) check("mon_done_id", done_id, exp_id);
`ifdef CNT_SEQ_ABORT_EN
    check("mon_aborted", aborted, exp_done && exp_ab);
`endif
    if (!rst) begin
      exp_gnt  = '0;
      exp_done = 0;
      if (m_job) begin
`ifdef CNT_SEQ_ABORT_EN
        // Abort counts only while loading or counting; the job then finishes 3 cycles later.
        if (abort && !m_ab && m_el <= m_steps) begin
          m_ab      = 1;
          m_done_at = m_el + 3;
          tmp       = m_dir ? m_load + m_el : m_load - m_el;
          m_exp     = tmp[W-1:0];
        end
`endif
        m_el++;
        if (m_el == m_done_at) begin
          exp_done = 1;
          exp_id   = m_id[IW-1:0];
          exp_res  = m_exp;
          exp_ab   = m_ab;
          exp_busy = 0;
          m_job    = 0;
        end
      end else begin
        found = 0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
          if (!found && req[(m_ptr + k) % N]) begin
            found = 1;
            idx   = (m_ptr + k) % N;
          end
        end
        if (found) begin
          exp_gnt      = '0;
          exp_gnt[idx] = 1'b1;
          exp_busy     = 1;
          m_job        = 1;
          m_ab         = 0;
          m_el         = 0;
          m_id         = idx;
          m_load       = int'(req_load[idx*W +: W]);
          m_dir        = req_dir[idx];
          m_steps      = int'(req_steps[idx*SW +: SW]);
          m_done_at    = m_steps + 3;
          tmp          = m_dir ? m_load + m_steps : m_load - m_steps;
          m_exp        = tmp[W-1:0];
          m_ptr        = (idx + 1) % N;
        end
      end
    end
  end

  task automatic set_job(input int id, input seq_job_t j);
    req_load[id*W +: W]    = j.load;
    req_dir[id]            = j.dir;
    req_steps[id*SW +: SW] = j.steps;
  endtask

  task automatic wait_gnt(input string name, output int t);
    t = 0;
    @(posedge clk); #2;
    while (gnt == '0 && t < 50) begin
      @(posedge clk); #2;
      t++;
    end
    if (t >= 50) check({name, "_gnt_timeout"}, 1, 0);
  endtask

  task automatic wait_done(input string name, output int lat);
    lat = 0;
    do begin
      @(posedge clk); #2;
      lat++;
    end while (!done && lat < 300);
    if (!done) check({name, "_done_timeout"}, 1, 0);
  endtask

  task automatic run_job(input string name, input int id, input seq_job_t j,
                         input logic [N-1:0] exp_g, input logic [W-1:0] exp_r, input int exp_lat);
    int t, lat;
    set_job(id, j);
    req[id] = 1'b1;
    wait_gnt(name, t);
    check({name, "_gnt_latency"}, t, 0);
    check({name, "_gnt"}, gnt, exp_g);
    req[id] = 1'b0;
    wait_done(name, lat);
    check({name, "_done_latency"}, lat, exp_lat);
    check({name, "_result"}, result, exp_r);
    check({name, "_done_id"}, done_id, id);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_gnt"}, gnt, 0);
    check({name, "_done"}, done, 0);
    check({name, "_done_id"}, done_id, 0);
    check({name, "_result"}, result, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_load_n"}, load_n, 1);
    check({name, "_ce"}, ce, 0);
    check({name, "_up_down"}, up_down, 0);
    check({name, "_data_load"}, data_load, 0);
`ifdef CNT_SEQ_ABORT_EN
    check({name, "_aborted"}, aborted, 0);
`endif
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int t, lat;
    rst       = 1'b1;
    req       = '0;
    req_load  = '0;
    req_dir   = '0;
    req_steps = '0;
`ifdef CNT_SEQ_ABORT_EN
    abort     = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    // Fairness: all four requesters hold req with 1-step jobs; grants must rotate 0,1,2,3,...
    for (int i = 0; i < N; i++) set_job(i, '{load: 4'(3 * i), dir: i[0], steps: 8'd1});
    req = '1;
    for (int k = 0; k < 8; k++) begin
      wait_gnt("rr", t);
      check("rr_order", gnt, 4'b0001 << (k % N));
    end
    req = '0;
    wait_done("rr_last", lat);
    check("rr_last_result", result, 4'd10);
    repeat (2) @(posedge clk);
    #2;

    // Single job up: 3 + 5 = 8, done 8 cycles after gnt.
    run_job("single", 0, '{load: 4'd3, dir: 1'b1, steps: 8'd5}, 4'b0001, 4'd8, 8);
    // Down-wrap: 1 - 3 = 14 mod 16.
    run_job("downwrap", 2, '{load: 4'd1, dir: 1'b0, steps: 8'd3}, 4'b0100, 4'd14, 6);
    // Zero steps: no counting at all, result is the load value.
    ce_seen = 1'b0;
    run_job("zero", 1, '{load: 4'd9, dir: 1'b0, steps: 8'd0}, 4'b0010, 4'd9, 3);
    check("zero_ce_never", ce_seen, 0);

    // Reset mid-job: pointer is at 3 before reset, must restart at 0.
    set_job(2, '{load: 4'd5, dir: 1'b1, steps: 8'd20});
    req[2] = 1'b1;
    wait_gnt("rstjob", t);
    check("rstjob_gnt", gnt, 4'b0100);
    req[2] = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    check("rstjob_ce_mid", ce, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #2;
    rst = 1'b0;
    set_job(1, '{load: 4'd7, dir: 1'b0, steps: 8'd2});
    set_job(3, '{load: 4'd2, dir: 1'b1, steps: 8'd1});
    req = 4'b1010;
    wait_gnt("postrst", t);
    check("postrst_gnt", gnt, 4'b0010);
    req = '0;
    wait_done("postrst", lat);
    check("postrst_latency", lat, 5);
    check("postrst_result", result, 4'd5);
    check("postrst_done_id", done_id, 1);

`ifdef CNT_SEQ_ABORT_EN
    // Abort on the 4th COUNT cycle of a 10-step up job from 0: four edges counted.
    repeat (2) @(posedge clk);
    #2;
    set_job(0, '{load: 4'd0, dir: 1'b1, steps: 8'd10});
    req[0] = 1'b1;
    wait_gnt("abort", t);
    check("abort_gnt", gnt, 4'b0001);
    req[0] = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    abort = 1'b1;
    @(posedge clk);
    #2;
    abort = 1'b0;
    lat = 1;
    while (!done && lat < 50) begin
      @(posedge clk);
      #2;
      lat++;
    end
    check("abort_done_cycle", lat, 3);
    check("abort_result", result, 4'd4);
    check("abort_flag", aborted, 1);
    check("abort_done_id", done_id, 0);
`endif

    repeat (3) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
